wishbone_bus_if: RTL and testbench

WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

---
 rtl/wishbone_bus_if_pkg.sv | 17 +
 rtl/wishbone_bus_if.sv | 130 +++++++++++++
 tb/tb_wishbone_bus_if.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// rtl/wishbone_bus_if_pkg.sv - shared widths, constants and FSM encoding for the CPU-to-Wishbone bridge
package wishbone_bus_if_pkg;

  localparam int RegBus   = 32;
  localparam int StallBus = 6;

  localparam logic               Enable   = 1'b1;
  localparam logic               Disable  = 1'b0;
  localparam logic [RegBus-1:0]  ZeroWord = '0;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wishbone_bus_if.sv
// rtl/wishbone_bus_if.sv - single-outstanding Wishbone master bridging one CPU memory port
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [3:0]          cpu_sel_i,
  input  logic [RegBus-1:0]   cpu_addr_i,
  input  logic [RegBus-1:0]   cpu_data_i,
  output logic [RegBus-1:0]   cpu_data_o,
  output logic                stallreq,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [3:0]          wb_sel_o,
  output logic [RegBus-1:0]   wb_adr_o,
  output logic [RegBus-1:0]   wb_dat_o,
  input  logic [RegBus-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  wb_state_e         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [RegBus-1:0] adr_q, adr_d;
  logic [RegBus-1:0] dat_q, dat_d;
  logic [RegBus-1:0] rd_buf_q, rd_buf_d;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rd_buf_d = rd_buf_q;
    case (state_q)
      WB_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          cyc_d   = Enable;
          stb_d   = Enable;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          state_d = WB_BUSY;
        end
      end
      WB_BUSY: begin
        // flush wins over a same-cycle ack so an abandoned read never lands in rd_buf
        if (flush_i || wb_ack_i) begin
          cyc_d = Disable;
          stb_d = Disable;
          we_d  = Disable;
          sel_d = 4'b0000;
          adr_d = ZeroWord;
          dat_d = ZeroWord;
          if (flush_i) begin
            rd_buf_d = ZeroWord;
            state_d  = WB_IDLE;
          end else begin
            if (!we_q) rd_buf_d = wb_dat_i;
            state_d = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end
        end
      end
      WB_WAIT_FOR_STALL: begin
        if (flush_i) begin
          rd_buf_d = ZeroWord;
          state_d  = WB_IDLE;
        end else if (stall_i == '0) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WB_IDLE;
      cyc_q    <= Disable;
      stb_q    <= Disable;
      we_q     <= Disable;
      sel_q    <= 4'b0000;
      adr_q    <= ZeroWord;
      dat_q    <= ZeroWord;
      rd_buf_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // ack-cycle data bypasses rd_buf so the CPU sees read data with no extra cycle
  always_comb begin
    stallreq   = Disable;
    cpu_data_o = ZeroWord;
    case (state_q)
      WB_IDLE: stallreq = cpu_ce_i & ~flush_i;
      WB_BUSY: begin
        if (wb_ack_i) cpu_data_o = wb_dat_i;
        else          stallreq   = Enable;
      end
      WB_WAIT_FOR_STALL: cpu_data_o = rd_buf_q;
      default: ;
    endcase
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// tb/tb_wishbone_bus_if.sv - self-checking bench for wishbone_bus_if against a transaction-level model
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  wishbone_bus_if dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: an outstanding bus request (if any), and a word held for a stalled pipeline.
  bit          m_out = 0;
  bit          m_we = 0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_adr = '0, m_dat = '0;
  bit          m_hold = 0;
  logic [31:0] m_buf = '0;

  task automatic next_cycle();
    @(negedge clk);
    rst = 0; stall_i = '0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0;
    cpu_sel_i = '0; cpu_addr_i = '0; cpu_data_i = '0; wb_dat_i = '0; wb_ack_i = 0;
  endtask

  task automatic eval();
    logic [31:0] e_data;
    logic        e_stall;
    #1;
    if (m_out) begin
      e_stall = !wb_ack_i;
      e_data  = wb_ack_i ? wb_dat_i : 32'h0;
    end else if (m_hold) begin
      e_stall = 0;
      e_data  = m_buf;
    end else begin
      e_stall = cpu_ce_i & ~flush_i;
      e_data  = 32'h0;
    end
    check("stallreq", {31'h0, stallreq}, {31'h0, e_stall});
    check("cpu_data", cpu_data_o, e_data);
    check("cyc", {31'h0, wb_cyc_o}, {31'h0, m_out});
    check("stb", {31'h0, wb_stb_o}, {31'h0, m_out});
    check("stb_without_cyc", {31'h0, wb_stb_o & ~wb_cyc_o}, 32'h0);
    check("we", {31'h0, wb_we_o}, {31'h0, m_out & m_we});
    check("sel", {28'h0, wb_sel_o}, m_out ? {28'h0, m_sel} : 32'h0);
    check("adr", wb_adr_o, m_out ? m_adr : 32'h0);
    check("dat", wb_dat_o, m_out ? m_dat : 32'h0);
    if (rst) begin
      m_out = 0; m_hold = 0; m_buf = '0;
    end else if (m_out) begin
      if (flush_i) begin
        m_out = 0; m_buf = '0;
      end else if (wb_ack_i) begin
        m_out = 0;
        if (!m_we) m_buf = wb_dat_i;
        m_hold = (stall_i != 0);
      end
    end else if (m_hold) begin
      if (flush_i) begin
        m_hold = 0; m_buf = '0;
      end else if (stall_i == 0) begin
        m_hold = 0;
      end
    end else if (cpu_ce_i && !flush_i) begin
      m_out = 1; m_we = cpu_we_i; m_sel = cpu_sel_i; m_adr = cpu_addr_i; m_dat = cpu_data_i;
    end
  endtask

  task automatic request(input bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    next_cycle();
    cpu_ce_i = 1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = adr; cpu_data_i = dat;
    eval();
  endtask

  initial begin
    next_cycle(); rst = 1; eval();
    next_cycle(); eval();
    check("reset_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("reset_stallreq", {31'h0, stallreq}, 32'h0);

    // read with three wait cycles
    request(0, 4'hF, 32'h0000_0100, 32'h0);
    check("rd_req_stallreq", {31'h0, stallreq}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); eval();
      check("rd_wait_stallreq", {31'h0, stallreq}, 32'h1);
    end
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF; eval();
    check("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
    check("rd_ack_stallreq", {31'h0, stallreq}, 32'h0);
    next_cycle(); eval();
    check("rd_done_cyc", {31'h0, wb_cyc_o}, 32'h0);

    // write
    request(1, 4'b0011, 32'h0000_0010, 32'h1234_5678);
    next_cycle(); eval();
    check("wr_adr", wb_adr_o, 32'h0000_0010);
    check("wr_sel", {28'h0, wb_sel_o}, 32'h3);
    check("wr_dat", wb_dat_o, 32'h1234_5678);
    check("wr_we", {31'h0, wb_we_o}, 32'h1);
    next_cycle(); wb_ack_i = 1; eval();
    next_cycle(); eval();
    check("wr_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);

    // ack during a pipeline stall holds the word
    request(0, 4'hF, 32'h0000_0020, 32'h0);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'hCAFE_F00D; stall_i = 6'b001111; eval();
    for (int i = 0; i < 2; i++) begin
      next_cycle(); stall_i = 6'b001111; eval();
      check("held_data", cpu_data_o, 32'hCAFE_F00D);
    end
    next_cycle(); eval();
    next_cycle(); eval();
    check("held_released", cpu_data_o, 32'h0);

    // flush with simultaneous ack, then expose rd_buf through a stalled write
    request(0, 4'hF, 32'h0000_0030, 32'h0);
    next_cycle(); flush_i = 1; wb_ack_i = 1; wb_dat_i = 32'hBAD0_BAD0; eval();
    next_cycle(); eval();
    check("flush_cyc", {31'h0, wb_cyc_o}, 32'h0);
    request(1, 4'hF, 32'h0000_0040, 32'h5555_AAAA);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h7777_7777; stall_i = 6'b000001; eval();
    next_cycle(); stall_i = 6'b000001; eval();
    check("flush_rdbuf", cpu_data_o, 32'h0);
    next_cycle(); eval();

    // reset mid-access, then a late ack
    request(0, 4'hF, 32'h0000_0050, 32'h0);
    next_cycle(); rst = 1; eval();
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h9999_9999; eval();
    check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst_late_ack", cpu_data_o, 32'h0);

    // back-to-back reads
    request(0, 4'hF, 32'h0000_0000, 32'h0);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h1111_1111; eval();
    check("b2b_first", cpu_data_o, 32'h1111_1111);
    request(0, 4'hF, 32'h0000_0004, 32'h0);
    next_cycle(); wb_ack_i = 1; wb_dat_i = 32'h2222_2222; eval();
    check("b2b_adr", wb_adr_o, 32'h0000_0004);
    check("b2b_second", cpu_data_o, 32'h2222_2222);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      rst        = ($urandom_range(99) < 2);
      flush_i    = ($urandom_range(99) < 10);
      stall_i    = ($urandom_range(99) < 25) ? 6'($urandom_range(63, 1)) : 6'h0;
      cpu_ce_i   = $urandom_range(1);
      cpu_we_i   = $urandom_range(1);
      cpu_sel_i  = 4'($urandom);
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      wb_ack_i   = ($urandom_range(99) < 40);
      wb_dat_i   = $urandom;
      eval();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
